// File: rtl/airlock_pkg.sv
// airlock_pkg
// Shared definitions for the airlock sequencing logic:
//   - timerState_t : run-controller states of the elapsed-seconds timer
//   - SEG_*        : active-low 7-segment patterns, segment order gfedcba
//   - *_SEC        : dwell thresholds the leaving/arriving FSMs compare
//                    against the timer count
package airlock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timerState_t;

  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT1 = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT2 = 7'b0100100;
  localparam logic [6:0] SEG_DIGIT3 = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT4 = 7'b0011001;
  localparam logic [6:0] SEG_DIGIT5 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT6 = 7'b0000010;
  localparam logic [6:0] SEG_DIGIT7 = 7'b1111000;

  localparam int LAMP_SEC  = 1;
  localparam int EVAC_SEC  = 2;
  localparam int PRESS_SEC = 4;

endpackage

// File: rtl/airlock_second_timer_seg7_digit.sv
// seg7_digit
// Combinational 3-bit digit to active-low 7-segment decoder (gfedcba).
// Only compiled when AIRLOCK_TIMER_DISPLAY_EN is defined, since it is used
// solely by the optional display of airlock_second_timer.
// Ports:
//   digit    : input  [2:0] value 0..7
//   segments : output [6:0] active-low segment pattern
`ifdef AIRLOCK_TIMER_DISPLAY_EN
module seg7_digit
  import airlock_pkg::*;
(
  input  logic [2:0] digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_BLANK;
    case (digit)
      3'd0: segments = SEG_DIGIT0;
      3'd1: segments = SEG_DIGIT1;
      3'd2: segments = SEG_DIGIT2;
      3'd3: segments = SEG_DIGIT3;
      3'd4: segments = SEG_DIGIT4;
      3'd5: segments = SEG_DIGIT5;
      3'd6: segments = SEG_DIGIT6;
      3'd7: segments = SEG_DIGIT7;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule
`endif

// File: rtl/airlock_second_timer.sv
// airlock_second_timer
// Elapsed-seconds timer for the airlock sequencing FSMs. A prescaler divides
// the board clock to 1 s ticks; a saturating seconds counter is driven by a
// three-state run controller (IDLE / RUN / HOLD).
// Optional feature macro: AIRLOCK_TIMER_DISPLAY_EN adds a registered
// active-low 7-segment display output of the count.
// Ports:
//   clock    : input          system clock, posedge
//   rst      : input          synchronous active-high reset, dominates all
//   clear    : input          restart request (FSM rstCounter)
//   enable   : input          count gate while in RUN
//   count    : output [CNT_W] elapsed whole seconds since last clear
//   sec_tick : output         one-cycle pulse when count takes a new value
//   sat      : output         high while count is held at its maximum
//   display  : output [6:0]   (AIRLOCK_TIMER_DISPLAY_EN only) gfedcba, active-low
module airlock_second_timer
  import airlock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 390625,
  parameter int PRESC_W       = 19,
  parameter int CNT_W         = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             sec_tick,
  output logic             sat
`ifdef AIRLOCK_TIMER_DISPLAY_EN
  ,
  output logic [6:0]       display
`endif
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

  timerState_t        stateReg;
  logic [PRESC_W-1:0] prescReg;
  logic [CNT_W-1:0]   countInc;
  logic               tickNow;

  assign countInc = count + 1'b1;
  // A second elapses on this edge only when running, enabled and the
  // prescaler has reached its last value; clear overrides it below.
  assign tickNow  = (stateReg == RUN) && enable && (prescReg == PRESC_LAST);

  always_ff @(posedge clock) begin
    if (rst) begin
      stateReg <= IDLE;
      prescReg <= '0;
      count    <= '0;
      sec_tick <= 1'b0;
      sat      <= 1'b0;
    end else if (clear) begin
      // clear wins over a coincident tick and restarts from zero
      stateReg <= RUN;
      prescReg <= '0;
      count    <= '0;
      sec_tick <= 1'b0;
      sat      <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          prescReg <= '0;
          count    <= '0;
          sec_tick <= 1'b0;
          sat      <= 1'b0;
        end
        RUN: begin
          if (tickNow) begin
            prescReg <= '0;
            count    <= countInc;
            sec_tick <= 1'b1;
            if (countInc == CNT_MAX) begin
              stateReg <= HOLD;
              sat      <= 1'b1;
            end
          end else begin
            // enable low freezes the prescaler so no partial second is lost
            if (enable) begin
              prescReg <= prescReg + 1'b1;
            end
            sec_tick <= 1'b0;
          end
        end
        HOLD: begin
          sec_tick <= 1'b0;
          sat      <= 1'b1;
        end
        default: begin
          stateReg <= IDLE;
          prescReg <= '0;
          count    <= '0;
          sec_tick <= 1'b0;
          sat      <= 1'b0;
        end
      endcase
    end
  end

`ifdef AIRLOCK_TIMER_DISPLAY_EN
  logic [6:0] incSegments;

  // Decode the value count is about to take so display moves on the same
  // edge as count rather than one cycle behind it.
  seg7_digit u_seg7Digit (
    .digit    (3'(countInc)),
    .segments (incSegments)
  );

  always_ff @(posedge clock) begin
    if (rst) begin
      display <= SEG_BLANK;
    end else if (clear) begin
      display <= SEG_DIGIT0;
    end else begin
      case (stateReg)
        RUN: begin
          if (tickNow) begin
            display <= incSegments;
          end
        end
        HOLD: begin
          display <= display;
        end
        default: begin
          display <= SEG_BLANK;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_airlock_second_timer.sv
// tb_airlock_second_timer
// Directed self-checking bench for airlock_second_timer with
// TICKS_PER_SEC=4, CNT_W=3. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge.
module tb_airlock_second_timer;
  import airlock_pkg::*;

  localparam int TPS   = 4;
  localparam int PW    = 3;
  localparam int CW    = 3;
  localparam int CMAX  = 7;

  logic          clock;
  logic          rst;
  logic          clear;
  logic          enable;
  logic [CW-1:0] count;
  logic          sec_tick;
  logic          sat;
`ifdef AIRLOCK_TIMER_DISPLAY_EN
  logic [6:0]    display;
`endif

  int vecCount;
  int errCount;

  airlock_second_timer #(
    .TICKS_PER_SEC (TPS),
    .PRESC_W       (PW),
    .CNT_W         (CW)
  ) dut (
    .clock    (clock),
    .rst      (rst),
    .clear    (clear),
    .enable   (enable),
    .count    (count),
    .sec_tick (sec_tick),
    .sat      (sat)
`ifdef AIRLOCK_TIMER_DISPLAY_EN
    ,
    .display  (display)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      vecCount++;
      if (count !== 3'd0 || sat !== 1'b0 || sec_tick !== 1'b0) begin
        errCount++;
        $display("FAIL reset_outputs cyc%0d: count=%0d sat=%b tick=%b, required 0/0/0", i, count, sat, sec_tick);
      end
    end
    vecCount++;
    if (dut.stateReg !== IDLE) begin
      errCount++;
      $display("FAIL reset_state: got %0d required IDLE", dut.stateReg);
    end
`ifdef AIRLOCK_TIMER_DISPLAY_EN
    vecCount++;
    if (display !== SEG_BLANK) begin
      errCount++;
      $display("FAIL reset_display: got %b required %b", display, SEG_BLANK);
    end
`endif
    rst = 1'b0; clear = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      vecCount++;
      if (count !== 3'd0 || sec_tick !== 1'b0) begin
        errCount++;
        $display("FAIL idle_no_count cyc%0d: count=%0d tick=%b, required 0/0", i, count, sec_tick);
      end
    end
    $display("test_reset done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask

  task automatic test_count();
    int ticks;
    ticks = 0;
    enable = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    vecCount++;
    if (count !== 3'd0 || sec_tick !== 1'b0) begin
      errCount++;
      $display("FAIL count_after_clear: count=%0d tick=%b, required 0/0", count, sec_tick);
    end
    for (int i = 1; i <= 16; i++) begin
      step();
      if (sec_tick === 1'b1) ticks++;
      vecCount++;
      if (count !== CW'(i / TPS) || sec_tick !== ((i % TPS) == 0)) begin
        errCount++;
        $display("FAIL count_seq cyc%0d: count=%0d tick=%b, required %0d/%b", i, count, sec_tick, i / TPS, (i % TPS) == 0);
      end
      if (i == LAMP_SEC * TPS || i == EVAC_SEC * TPS || i == PRESS_SEC * TPS) begin
        vecCount++;
        if (int'(count) != i / TPS) begin
          errCount++;
          $display("FAIL dwell_threshold cyc%0d: count=%0d required %0d", i, count, i / TPS);
        end
      end
    end
    vecCount++;
    if (ticks != 4) begin
      errCount++;
      $display("FAIL tick_total: got %0d required 4", ticks);
    end
    $display("test_count done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask

  task automatic test_saturate();
    int expCount;
    enable = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      expCount = (i / TPS > CMAX) ? CMAX : i / TPS;
      vecCount++;
      if (int'(count) != expCount || sat !== (i >= 28) ||
          sec_tick !== ((i % TPS) == 0 && i <= 28)) begin
        errCount++;
        $display("FAIL saturate cyc%0d: count=%0d sat=%b tick=%b, required %0d/%b/%b",
                 i, count, sat, sec_tick, expCount, i >= 28, (i % TPS) == 0 && i <= 28);
      end
    end
`ifdef AIRLOCK_TIMER_DISPLAY_EN
    vecCount++;
    if (display !== SEG_DIGIT7) begin
      errCount++;
      $display("FAIL display_hold: got %b required %b", display, SEG_DIGIT7);
    end
`endif
    clear = 1'b1;
    step();
    clear = 1'b0;
    vecCount++;
    if (count !== 3'd0 || sat !== 1'b0) begin
      errCount++;
      $display("FAIL sat_clear: count=%0d sat=%b, required 0/0", count, sat);
    end
    repeat (4) step();
    vecCount++;
    if (count !== 3'd1 || sec_tick !== 1'b1) begin
      errCount++;
      $display("FAIL sat_restart: count=%0d tick=%b, required 1/1", count, sec_tick);
    end
    $display("test_saturate done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask

  task automatic test_pause();
    enable = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (2) step();
    enable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      vecCount++;
      if (count !== 3'd0 || sec_tick !== 1'b0) begin
        errCount++;
        $display("FAIL pause_hold cyc%0d: count=%0d tick=%b, required 0/0", i, count, sec_tick);
      end
    end
    enable = 1'b1;
    step();
    vecCount++;
    if (count !== 3'd0 || sec_tick !== 1'b0) begin
      errCount++;
      $display("FAIL resume_1: count=%0d tick=%b, required 0/0", count, sec_tick);
    end
    step();
    vecCount++;
    if (count !== 3'd1 || sec_tick !== 1'b1) begin
      errCount++;
      $display("FAIL resume_2: count=%0d tick=%b, required 1/1", count, sec_tick);
    end
    $display("test_pause done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask

  task automatic test_clear_on_tick();
    enable = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (11) step();
    vecCount++;
    if (count !== 3'd2) begin
      errCount++;
      $display("FAIL pre_tick_count: got %0d required 2", count);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vecCount++;
    if (count !== 3'd0 || sec_tick !== 1'b0) begin
      errCount++;
      $display("FAIL clear_beats_tick: count=%0d tick=%b, required 0/0", count, sec_tick);
    end
    repeat (3) step();
    vecCount++;
    if (count !== 3'd0) begin
      errCount++;
      $display("FAIL clear_tick_early: got %0d required 0", count);
    end
    step();
    vecCount++;
    if (count !== 3'd1 || sec_tick !== 1'b1) begin
      errCount++;
      $display("FAIL clear_tick_next: count=%0d tick=%b, required 1/1", count, sec_tick);
    end
    $display("test_clear_on_tick done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask

  task automatic test_clear_held();
    enable = 1'b1; clear = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      vecCount++;
      if (count !== 3'd0 || sec_tick !== 1'b0) begin
        errCount++;
        $display("FAIL clear_held cyc%0d: count=%0d tick=%b, required 0/0", i, count, sec_tick);
      end
    end
    clear = 1'b0;
    repeat (3) step();
    vecCount++;
    if (count !== 3'd0) begin
      errCount++;
      $display("FAIL clear_release_early: got %0d required 0", count);
    end
    step();
    vecCount++;
    if (count !== 3'd1) begin
      errCount++;
      $display("FAIL clear_release_tick: got %0d required 1", count);
    end
    $display("test_clear_held done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask

  task automatic test_rst_mid();
    repeat (8) step();
    rst = 1'b1; clear = 1'b1;
    step();
    vecCount++;
    if (count !== 3'd0 || sat !== 1'b0 || sec_tick !== 1'b0 || dut.stateReg !== IDLE) begin
      errCount++;
      $display("FAIL rst_mid: count=%0d sat=%b tick=%b state=%0d, required 0/0/0/IDLE",
               count, sat, sec_tick, dut.stateReg);
    end
    rst = 1'b0; clear = 1'b0;
    step();
    $display("test_rst_mid done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask

`ifdef AIRLOCK_TIMER_DISPLAY_EN
  task automatic test_display();
    enable = 1'b1;
    vecCount++;
    if (display !== SEG_BLANK) begin
      errCount++;
      $display("FAIL display_idle: got %b required %b", display, SEG_BLANK);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    vecCount++;
    if (display !== SEG_DIGIT0) begin
      errCount++;
      $display("FAIL display_zero: got %b required %b", display, SEG_DIGIT0);
    end
    repeat (12) step();
    vecCount++;
    if (count !== 3'd3 || display !== SEG_DIGIT3) begin
      errCount++;
      $display("FAIL display_three: count=%0d display=%b, required 3/%b", count, display, SEG_DIGIT3);
    end
    repeat (20) step();
    vecCount++;
    if (sat !== 1'b1 || display !== SEG_DIGIT7) begin
      errCount++;
      $display("FAIL display_sat: sat=%b display=%b, required 1/%b", sat, display, SEG_DIGIT7);
    end
    $display("test_display done: vectors=%0d miscompares=%0d", vecCount, errCount);
  endtask
`endif

  initial begin
    vecCount = 0;
    errCount = 0;
    rst = 1'b1; clear = 1'b0; enable = 1'b0;
    test_reset();
    test_count();
    test_saturate();
    test_pause();
    test_clear_on_tick();
    test_clear_held();
    test_rst_mid();
`ifdef AIRLOCK_TIMER_DISPLAY_EN
    test_display();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
